// File: rtl/present_pkg.sv
// Shared constants, FSM encoding and S-box helpers for the PRESENT-80 encryption core.
package present_pkg;

  localparam int BLOCK_W        = 64;
  localparam int KEY_W          = 80;
  localparam int NUM_ROUNDS_DEF = 31;

  // Nibble n of this word is S(n).
  localparam logic [63:0] SBOX_TABLE = 64'h21748FE3_DA09B65C;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } fsm_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int n = 0; n < BLOCK_W / 4; n++) begin
      y[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    return y;
  endfunction

endpackage

// File: rtl/pLayer_Enc.sv
// PRESENT forward bit permutation: bit j moves to 16*j mod 63, bit 63 stays put.
module pLayer_Enc
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  for (genvar j = 0; j < BLOCK_W - 1; j++) begin : g_perm
    assign dout[(16 * j) % 63] = din[j];
  end

  assign dout[BLOCK_W-1] = din[BLOCK_W-1];

endmodule

// File: rtl/present_enc_core.sv
// Iterative PRESENT-80 encryption: one round per clock, K32 whitening folded into the final round.
//
//   state | meaning
//   IDLE  | ready for a new block; enable_in starts an operation
//   ROUND | running rounds 1..NUM_ROUNDS, enable_in ignored
module present_enc_core
  import present_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] state,
  input  logic [KEY_W-1:0]   key,
  input  logic               enable_in,
  output logic               ready,
  output logic [BLOCK_W-1:0] out,
  output logic               enable_out
);

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

  fsm_t               fsm_q;
  fsm_t               fsm_d;
  logic [BLOCK_W-1:0] data_q;
  logic [KEY_W-1:0]   key_q;
  logic [4:0]         round_q;
  logic               start;
  logic               last;

  logic [BLOCK_W-1:0] sbox_out;
  logic [BLOCK_W-1:0] perm_out;
  logic [KEY_W-1:0]   key_rot;
  logic [KEY_W-1:0]   key_next;

  assign sbox_out = sbox_layer(data_q ^ key_q[KEY_W-1:16]);

  pLayer_Enc u_player (
    .din  (sbox_out),
    .dout (perm_out)
  );

  // Key schedule: rotate left by 61, S-box the top nibble, mix in the round index.
  always_comb begin
    key_rot          = {key_q[18:0], key_q[KEY_W-1:19]};
    key_next         = key_rot;
    key_next[79:76]  = sbox4(key_rot[79:76]);
    key_next[19:15]  = key_rot[19:15] ^ round_q;
  end

  always_comb begin
    fsm_d = fsm_q;
    start = 1'b0;
    last  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (enable_in) begin
          start = 1'b1;
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        if (round_q == LAST_ROUND) begin
          last  = 1'b1;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign ready = (fsm_q == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q     <= '0;
      key_q      <= '0;
      round_q    <= '0;
      out        <= '0;
      enable_out <= 1'b0;
    end else begin
      enable_out <= last;
      if (start) begin
        data_q  <= state;
        key_q   <= key;
        round_q <= 5'd1;
      end else if (fsm_q == ROUND) begin
        data_q  <= perm_out;
        key_q   <= key_next;
        // Park the counter at 0 on completion so it never wraps.
        round_q <= last ? 5'd0 : round_q + 5'd1;
      end
      if (last) begin
        out <= perm_out ^ key_next[KEY_W-1:16];
      end
    end
  end

endmodule

// File: tb/tb_present_enc_core.sv
// Directed bench for present_enc_core using the published PRESENT-80 test vectors.
module tb_present_enc_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] state = '0;
  logic [79:0] key   = '0;
  logic        enable_in = 1'b0;
  logic        ready;
  logic [63:0] out;
  logic        enable_out;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] CT_00 = 64'h5579C1387B228445;
  localparam logic [63:0] CT_0F = 64'hE72C46C0F5945049;
  localparam logic [63:0] CT_F0 = 64'hA112FFC72F68417B;
  localparam logic [63:0] CT_FF = 64'h3333DCD3213210D2;
  localparam logic [63:0] PT_F  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] K_F   = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

  present_enc_core #(.NUM_ROUNDS(31)) dut (
    .clock      (clock),
    .reset      (reset),
    .state      (state),
    .key        (key),
    .enable_in  (enable_in),
    .ready      (ready),
    .out        (out),
    .enable_out (enable_out)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input logic [63:0] pt, input logic [79:0] k);
    state     = pt;
    key       = k;
    enable_in = 1'b1;
    tick();
    enable_in = 1'b0;
  endtask

  // Counts edges until enable_out is seen (41 means it never came).
  task automatic wait_pulse(output int n, output bit ready_bad, output bit out_moved);
    logic [63:0] out0;
    out0      = out;
    n         = 0;
    ready_bad = 1'b0;
    out_moved = 1'b0;
    while (n <= 40) begin
      tick();
      n++;
      if (enable_out) break;
      if (ready) ready_bad = 1'b1;
      if (out !== out0) out_moved = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++;
    if (enable_out !== 1'b0) begin errors++; $display("FAIL reset_enable_out: got %b expected 0", enable_out); end
    checks++;
    if (out !== 64'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", out); end
  endtask

  task automatic test_vectors;
    logic [63:0] pt_v [4];
    logic [79:0] k_v  [4];
    logic [63:0] ct_v [4];
    int  n;
    bit  rb, om;
    pt_v[0] = 64'h0; k_v[0] = 80'h0; ct_v[0] = CT_00;
    pt_v[1] = 64'h0; k_v[1] = K_F;   ct_v[1] = CT_0F;
    pt_v[2] = PT_F;  k_v[2] = 80'h0; ct_v[2] = CT_F0;
    pt_v[3] = PT_F;  k_v[3] = K_F;   ct_v[3] = CT_FF;
    for (int i = 0; i < 4; i++) begin
      start_op(pt_v[i], k_v[i]);
      wait_pulse(n, rb, om);
      checks++;
      if (n != 31) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 31", i, n); end
      checks++;
      if (out !== ct_v[i]) begin errors++; $display("FAIL vec%0d_out: got %h expected %h", i, out, ct_v[i]); end
      checks++;
      if (ready !== 1'b1 || rb) begin errors++; $display("FAIL vec%0d_ready: got %b (busy-high %b) expected 1/0", i, ready, rb); end
      checks++;
      if (om) begin errors++; $display("FAIL vec%0d_out_stable: got change expected none during ROUND", i); end
      tick();
      checks++;
      if (enable_out !== 1'b0) begin errors++; $display("FAIL vec%0d_pulse_width: got %b expected 0", i, enable_out); end
      checks++;
      if (out !== ct_v[i]) begin errors++; $display("FAIL vec%0d_out_hold: got %h expected %h", i, out, ct_v[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit rb, om;
    start_op(PT_F, K_F);
    state     = 64'h0;
    key       = 80'h0;
    enable_in = 1'b1;
    wait_pulse(n, rb, om);
    checks++;
    if (n != 31 || out !== CT_FF) begin errors++; $display("FAIL b2b_first: got n=%0d out=%h expected 31 %h", n, out, CT_FF); end
    wait_pulse(n, rb, om);
    enable_in = 1'b0;
    checks++;
    if (n != 32) begin errors++; $display("FAIL b2b_spacing: got %0d expected 32", n); end
    checks++;
    if (out !== CT_00) begin errors++; $display("FAIL b2b_out: got %h expected %h", out, CT_00); end
    checks++;
    if (om || rb) begin errors++; $display("FAIL b2b_round_flags: got moved=%b ready=%b expected 0 0", om, rb); end
    tick();
    tick();
    checks++;
    if (ready !== 1'b1 || enable_out !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got ready=%b pulse=%b expected 1 0", ready, enable_out); end
  endtask

  task automatic test_ignore_midop;
    int n;
    int extra;
    bit rb;
    start_op(64'h0, K_F);
    n  = 0;
    rb = 1'b0;
    while (n <= 40) begin
      state     = {$urandom, $urandom};
      key       = {$urandom, $urandom, 16'($urandom)};
      enable_in = ~enable_in;
      tick();
      n++;
      if (enable_out) break;
      if (ready) rb = 1'b1;
    end
    enable_in = 1'b0;
    checks++;
    if (n != 31) begin errors++; $display("FAIL ignore_latency: got %0d expected 31", n); end
    checks++;
    if (out !== CT_0F) begin errors++; $display("FAIL ignore_out: got %h expected %h", out, CT_0F); end
    checks++;
    if (rb) begin errors++; $display("FAIL ignore_ready_in_round: got 1 expected 0"); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (enable_out) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL ignore_extra_pulses: got %0d expected 0", extra); end
  endtask

  task automatic test_reset_midop;
    int n;
    int pulses;
    bit rb, om;
    start_op(PT_F, 80'h0);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ready !== 1'b1 || enable_out !== 1'b0) begin errors++; $display("FAIL abort_state: got ready=%b pulse=%b expected 1 0", ready, enable_out); end
    checks++;
    if (out !== 64'h0) begin errors++; $display("FAIL abort_out: got %h expected 0", out); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (enable_out) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL abort_no_pulse: got %0d expected 0", pulses); end
    start_op(PT_F, 80'h0);
    wait_pulse(n, rb, om);
    checks++;
    if (n != 31 || out !== CT_F0) begin errors++; $display("FAIL abort_restart: got n=%0d out=%h expected 31 %h", n, out, CT_F0); end
  endtask

  task automatic test_reset_at_completion;
    int pulses;
    start_op(64'h0, 80'h0);
    for (int i = 0; i < 30; i++) tick();
    reset     = 1'b1;
    enable_in = 1'b1;
    tick();
    reset     = 1'b0;
    enable_in = 1'b0;
    checks++;
    if (enable_out !== 1'b0) begin errors++; $display("FAIL race_pulse: got %b expected 0", enable_out); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL race_ready: got %b expected 1", ready); end
    checks++;
    if (out !== 64'h0) begin errors++; $display("FAIL race_out: got %h expected 0", out); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (enable_out || !ready) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL race_stays_idle: got %0d busy/pulse cycles expected 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_ignore_midop();
    test_reset_midop();
    test_reset_at_completion();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
